// File: rtl/res_stim_gen.sv
// rtl/res_stim_gen.sv - packs streamed bytes into wide frames and replays a fixed-length run of them
module res_stim_gen #(
  parameter int ELEM_W    = 8,
  parameter int NUM_ELEM  = 40,
  parameter int NUM_FRAME = 64,
  parameter int GAP       = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ELEM_W-1:0]             byte_i,
  input  logic                          byte_valid_i,
  output logic                          byte_ready_o,
  output logic [ELEM_W*NUM_ELEM-1:0]    data_o,
  output logic                          valid_o,
  output logic [$clog2(NUM_FRAME)-1:0]  frame_idx_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int EW = $clog2(NUM_ELEM);
  localparam int FW = $clog2(NUM_FRAME);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAPW} state_t;

  state_t                     state_q, state_d;
  logic [EW-1:0]              elem_q, elem_d;
  logic [FW-1:0]              frame_q, frame_d;
  logic [GW-1:0]              gap_q, gap_d;
  logic [ELEM_W*NUM_ELEM-1:0] buf_q, buf_d;
  logic [ELEM_W*NUM_ELEM-1:0] data_q, data_d;
  logic [FW-1:0]              idx_q, idx_d;
  logic                       done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      elem_q  <= '0;
      frame_q <= '0;
      gap_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      frame_q <= frame_d;
      gap_q   <= gap_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    frame_d = frame_q;
    gap_d   = gap_q;
    buf_d   = buf_q;
    data_d  = data_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          elem_d  = '0;
          frame_d = '0;
        end
      end
      LOAD: begin
        if (byte_valid_i) begin
          buf_d[elem_q*ELEM_W +: ELEM_W] = byte_i;
          // The final byte goes straight into the emitted word, giving 1-cycle latency
          if (elem_q == EW'(NUM_ELEM - 1)) begin
            elem_d  = '0;
            data_d  = buf_d;
            idx_d   = frame_q;
            state_d = SEND;
          end else begin
            elem_d = elem_q + 1'b1;
          end
        end
      end
      SEND: begin
        gap_d = '0;
        if (frame_q == FW'(NUM_FRAME - 1)) begin
          frame_d = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          frame_d = frame_q + 1'b1;
          state_d = (GAP == 0) ? LOAD : GAPW;
        end
      end
      GAPW: begin
        if (gap_q == GW'(GAP - 1)) state_d = LOAD;
        else                       gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_ready_o = (state_q == LOAD);
  assign valid_o      = (state_q == SEND);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign data_o       = data_q;
  assign frame_idx_o  = idx_q;

endmodule

// File: tb/tb_res_stim_gen.sv
// tb/tb_res_stim_gen.sv - directed and randomized checks of res_stim_gen against a frame-level model
module tb_res_stim_gen;
  localparam int NE = 40;
  localparam int NF = 64;
  localparam int GP = 2;
  localparam int W  = NE * 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   byte_i = '0;
  logic         byte_valid_i = 1'b0;
  logic         byte_ready_o;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic [5:0]   frame_idx_o;
  logic         busy_o;
  logic         done_o;

  res_stim_gen #(.ELEM_W(8), .NUM_ELEM(NE), .NUM_FRAME(NF), .GAP(GP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_i(byte_i),
    .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o), .data_o(data_o),
    .valid_o(valid_o), .frame_idx_o(frame_idx_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_valid_cyc = -1;
  logic [7:0]   bytes [NE];
  logic [W-1:0] exp_word;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles 1,0,1,0, 2: random stalls
  task automatic run_frame(input int f, input int mode, input bit last,
                           input bit spacing, input bit poke_start);
    int k = 0;
    int guard = 0;
    bit vld;
    while (k < NE && guard < 400) begin
      vld = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
      byte_valid_i = vld;
      byte_i = vld ? bytes[k] : 8'($urandom);
      chk("ready_in_load", W'(byte_ready_o), W'(1));
      @(negedge clk);
      if (vld) k++;
      guard++;
    end
    chk("load_bound", W'(k), W'(NE));
    for (int i = 0; i < NE; i++) exp_word[i*8 +: 8] = bytes[i];
    byte_valid_i = 1'b1;
    byte_i = 8'($urandom);
    chk("valid_pulse", W'(valid_o), W'(1));
    chk("data", data_o, exp_word);
    chk("frame_idx", W'(frame_idx_o), W'(f));
    chk("ready_in_send", W'(byte_ready_o), W'(0));
    if (spacing && last_valid_cyc >= 0)
      chk("frame_spacing", W'(cyc - last_valid_cyc), W'(NE + 1 + GP));
    last_valid_cyc = cyc;
    if (last) begin
      @(negedge clk);
      byte_valid_i = 1'b0;
      chk("done_pulse", W'(done_o), W'(1));
      chk("valid_off_done", W'(valid_o), W'(0));
      chk("busy_off_done", W'(busy_o), W'(0));
      chk("data_hold_done", data_o, exp_word);
    end else begin
      for (int g = 0; g < GP; g++) begin
        if (poke_start) start = 1'b1;
        @(negedge clk);
        byte_i = 8'($urandom);
        chk("ready_in_gap", W'(byte_ready_o), W'(0));
        chk("valid_in_gap", W'(valid_o), W'(0));
        chk("data_hold_gap", data_o, exp_word);
      end
      start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", W'(byte_ready_o), W'(0));
    chk("rst_valid", W'(valid_o), W'(0));
    chk("rst_busy", W'(busy_o), W'(0));
    chk("rst_done", W'(done_o), W'(0));
    chk("rst_data", data_o, W'(0));
    chk("rst_idx", W'(frame_idx_o), W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_start", W'(busy_o), W'(0));

    // Run A: ramp frame, then byte value = frame index for the remaining frames
    start_run();
    chk("busy_after_start", W'(busy_o), W'(1));
    for (int f = 0; f < NF; f++) begin
      for (int i = 0; i < NE; i++) bytes[i] = (f == 0) ? 8'(i) : 8'(f);
      run_frame(f, 0, f == NF - 1, 1'b1, 1'b0);
      if (f == 0) begin
        chk("ramp_lsb", W'(data_o[7:0]), W'(8'h00));
        chk("ramp_msb", W'(data_o[W-1 -: 8]), W'(8'h27));
      end
    end

    // Start during the done cycle begins a new run immediately
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_ready", W'(byte_ready_o), W'(1));
    chk("restart_done_cleared", W'(done_o), W'(0));

    // Run B: stalls, start pokes while busy, then abort mid-frame 5
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < NE; i++) bytes[i] = 8'($urandom);
      run_frame(f, (f == 0) ? 1 : 2, 1'b0, 1'b0, f == 2);
    end
    for (int i = 0; i < 20; i++) begin
      byte_valid_i = 1'b1;
      byte_i = 8'($urandom);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", W'(byte_ready_o), W'(0));
    chk("abort_valid", W'(valid_o), W'(0));
    chk("abort_busy", W'(busy_o), W'(0));
    chk("abort_data", data_o, W'(0));
    chk("abort_idx", W'(frame_idx_o), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    byte_valid_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_valid", W'(valid_o), W'(0));
      chk("post_abort_done", W'(done_o), W'(0));
    end

    // Run C: fresh start counts from frame 0; check slot 39 of frame 7
    start_run();
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NE; i++) bytes[i] = 8'($urandom);
      run_frame(f, 2, 1'b0, 1'b0, 1'b0);
      if (f == 7) chk("f7_elem39", W'(data_o[39*8 +: 8]), W'(bytes[39]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
